// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: EX-stage load/store port vs. external port.
// Pipe has priority; starvation counter forces ext grants; dual ld+st splits.
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH  = 12,
  parameter int DMEM_WORD_WIDTH  = 16,
  parameter int STARVE_LIMIT     = 4,
  parameter int STARVE_CNT_WIDTH = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_pipe_rd_en,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_pipe_rd_addr,
  input  logic                       in_pipe_wr_en,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_pipe_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_pipe_wr_word,
  output logic                       out_pipe_stall,
  output logic [DMEM_WORD_WIDTH-1:0] out_pipe_rd_word,
  input  logic                       in_ext_valid,
  input  logic                       in_ext_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_ext_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_ext_wdata,
  output logic                       out_ext_ready,
  output logic                       out_ext_rvalid,
  output logic [DMEM_WORD_WIDTH-1:0] out_ext_rdata,
  output logic                       out_mem_en,
  output logic                       out_mem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_wdata,
  input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rdata
);

  typedef enum logic {
    ARB_PIPE,
    PIPE_WR
  } state_t;

  localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT =
    STARVE_CNT_WIDTH'(STARVE_LIMIT);

  state_t state, state_nxt;
  logic [STARVE_CNT_WIDTH-1:0] starve_cnt, starve_nxt;
  logic                        tag_pipe;
  logic                        rvalid_q;
  logic [DMEM_WORD_WIDTH-1:0]  held_word;

  logic pipe_req, ext_req;
  logic grant_ext, grant_pipe;
  logic pipe_rd_grant, ext_rd_grant;

  assign pipe_req = in_pipe_rd_en | in_pipe_wr_en;
  assign ext_req  = in_ext_valid;

  always_comb begin
    state_nxt      = state;
    grant_ext      = 1'b0;
    grant_pipe     = 1'b0;
    out_mem_en     = 1'b0;
    out_mem_we     = 1'b0;
    out_mem_addr   = '0;
    out_mem_wdata  = '0;
    out_pipe_stall = 1'b0;
    out_ext_ready  = 1'b0;
    unique case (state)
      ARB_PIPE: begin
        if (ext_req && (!pipe_req || starve_cnt == LIMIT)) begin
          grant_ext      = 1'b1;
          out_ext_ready  = 1'b1;
          out_mem_en     = 1'b1;
          out_mem_we     = in_ext_we;
          out_mem_addr   = in_ext_addr;
          out_mem_wdata  = in_ext_wdata;
          out_pipe_stall = pipe_req;
        end else if (pipe_req) begin
          grant_pipe = 1'b1;
          out_mem_en = 1'b1;
          if (in_pipe_rd_en) begin
            out_mem_addr = in_pipe_rd_addr;
            // Load goes first; the store follows next cycle.
            if (in_pipe_wr_en) begin
              out_pipe_stall = 1'b1;
              state_nxt      = PIPE_WR;
            end
          end else begin
            out_mem_we    = 1'b1;
            out_mem_addr  = in_pipe_wr_addr;
            out_mem_wdata = in_pipe_wr_word;
          end
        end
      end
      PIPE_WR: begin
        grant_pipe    = 1'b1;
        out_mem_en    = 1'b1;
        out_mem_we    = 1'b1;
        out_mem_addr  = in_pipe_wr_addr;
        out_mem_wdata = in_pipe_wr_word;
        state_nxt     = ARB_PIPE;
      end
    endcase
    if (reset) begin
      out_mem_en     = 1'b0;
      out_mem_we     = 1'b0;
      out_mem_addr   = '0;
      out_mem_wdata  = '0;
      out_pipe_stall = 1'b0;
      out_ext_ready  = 1'b0;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!ext_req || out_ext_ready)
      starve_nxt = '0;
    else if (starve_cnt != LIMIT)
      starve_nxt = starve_cnt + 1'b1;
  end

  assign pipe_rd_grant = grant_pipe & out_mem_en & ~out_mem_we;
  assign ext_rd_grant  = grant_ext & out_mem_en & ~out_mem_we;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ARB_PIPE;
      starve_cnt <= '0;
      tag_pipe   <= 1'b0;
      rvalid_q   <= 1'b0;
      held_word  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      tag_pipe   <= pipe_rd_grant;
      rvalid_q   <= ext_rd_grant;
      if (tag_pipe)
        held_word <= in_mem_rdata;
    end
  end

  // Pipe sees live memory data only right after its own read.
  always_comb begin
    out_pipe_rd_word = held_word;
    out_ext_rvalid   = rvalid_q;
    out_ext_rdata    = '0;
    if (tag_pipe)
      out_pipe_rd_word = in_mem_rdata;
    if (rvalid_q)
      out_ext_rdata = in_mem_rdata;
    if (reset) begin
      out_pipe_rd_word = '0;
      out_ext_rvalid   = 1'b0;
      out_ext_rdata    = '0;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the EX stage's load/store port and an external requester (debug/loader), sitting between the exec stage and the data memory. The pipeline has default priority. A starvation counter guarantees the external port a slot within a bounded number of cycles. A load and a store issued in the same cycle are split into two sequential memory accesses. A stall output freezes the pipeline whenever it is denied the port.

## Interface
- DMEM_ADDR_WIDTH, 12, data memory address width
- DMEM_WORD_WIDTH, 16, data memory word width
- STARVE_LIMIT, 4, max consecutive denied cycles for the external port before a forced grant (1..7)
- STARVE_CNT_WIDTH, 3, starvation counter width
- clock  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- in_pipe_rd_en  in  1  pipeline load request
- in_pipe_rd_addr  in  DMEM_ADDR_WIDTH  load address
- in_pipe_wr_en  in  1  pipeline store request
- in_pipe_wr_addr  in  DMEM_ADDR_WIDTH  store address
- in_pipe_wr_word  in  DMEM_WORD_WIDTH  store data
- out_pipe_stall  out  1  pipeline must hold its state and its request this cycle
- out_pipe_rd_word  out  DMEM_WORD_WIDTH  load data for the pipeline
- in_ext_valid  in  1  external request valid
- in_ext_we  in  1  external request is a write
- in_ext_addr  in  DMEM_ADDR_WIDTH  external address
- in_ext_wdata  in  DMEM_WORD_WIDTH  external write data
- out_ext_ready  out  1  external request accepted this cycle
- out_ext_rvalid  out  1  external read data valid
- out_ext_rdata  out  DMEM_WORD_WIDTH  external read data
- out_mem_en  out  1  memory access enable
- out_mem_we  out  1  memory write enable
- out_mem_addr  out  DMEM_ADDR_WIDTH  memory address
- out_mem_wdata  out  DMEM_WORD_WIDTH  memory write data
- in_mem_rdata  in  DMEM_WORD_WIDTH  memory read data; synchronous read, valid the cycle after an enabled read

## Operation
- Request terms:
  - pipe_req = in_pipe_rd_en | in_pipe_wr_en
  - ext_req = in_ext_valid
- FSM states:
  - ARB_PIPE (reset state)
  - PIPE_WR (second half of a dual load+store)
- Grant in ARB_PIPE:
  - Grant ext if ext_req & (!pipe_req | starve_cnt == STARVE_LIMIT).
  - Otherwise grant pipe if pipe_req.
  - Otherwise idle: out_mem_en = 0.
- Grant in PIPE_WR: always the pipeline store. The external port is never granted in this state.
- Ext grant:
  - out_ext_ready = 1; memory command taken from the in_ext_* inputs.
  - If pipe_req is also high, out_pipe_stall = 1.
- Pipe grant, single access:
  - Load: en=1, we=0, addr = rd_addr.
  - Store: en=1, we=1, addr = wr_addr, wdata = wr_word.
  - out_pipe_stall = 0.
- Pipe grant, rd_en & wr_en in ARB_PIPE:
  - Perform the load; out_pipe_stall = 1; next state PIPE_WR.
  - In PIPE_WR: perform the store; out_pipe_stall = 0; next state ARB_PIPE.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when ext_req & !out_ext_ready.
  - Clears when out_ext_ready = 1 or ext_req = 0.
  - Keeps counting in PIPE_WR, so a forced grant can fall on the first ARB_PIPE cycle afterwards.
- External handshake:
  - A transfer occurs when valid & ready.
  - in_ext_valid may drop before ready; the request is then abandoned and the counter clears.
  - On a read transfer, out_ext_rvalid = 1 on the next cycle, with out_ext_rdata = in_mem_rdata.
  - Writes produce no rvalid.
- Read-data routing:
  - A registered tag records whether the previous cycle's enabled read belonged to pipe or ext.
  - out_pipe_rd_word = in_mem_rdata when the tag is pipe; otherwise it shows a held register holding the last pipeline load data.
  - out_ext_rdata is the zero-extended mux: in_mem_rdata when out_ext_rvalid, else 0.
- All memory commands are combinational from the grant, adding no latency to the pipeline path.

## Timing
- Reset:
  - While reset is high, all outputs are 0: stall, ready, rvalid, rdata, pipe_rd_word, and all mem_* outputs.
  - State returns to ARB_PIPE; starve_cnt, tag and held word are 0.
- Reset asserted in the cycle after an ext read grant: rvalid stays 0 and the read data is dropped.
- Reset asserted mid dual access: the store is not performed. The pipeline re-issues after reset.
- Latency:
  - Memory command: 0 cycles from request.
  - Read data: 1 cycle after grant, for either requester.
- Worst-case ext wait under continuous pipe_req: STARVE_LIMIT denied cycles, plus 1 if a PIPE_WR cycle intervenes; grant on the next cycle.
- Forced ext grant: exactly one cycle. The pipeline wins the following cycle even if ext_req stays high (counter restarts from 0).
- Only one mem access per cycle. out_mem_we = 1 implies out_mem_en = 1.

## Test plan
- Reset release, pipe load 0x010, memory returns 0xBEEF -> cycle 0: mem_en=1, we=0, addr=0x010, stall=0; cycle 1: out_pipe_rd_word=0xBEEF.
- Ext write 0x020/0x1234, no pipe request -> same cycle ready=1, mem_we=1, addr=0x020, wdata=0x1234; rvalid stays 0.
- Continuous pipe loads plus ext read 0x030 from cycle 0 -> ready=0 in cycles 0-3. Cycle 4: ready=1, stall=1, addr=0x030. Cycle 5: rvalid=1, pipeline granted; out_pipe_rd_word still shows the previous pipe data.
- Pipe rd 0x040 & wr 0x041/0x5555 with ext_valid high -> cycle 0: read 0x040, stall=1. Cycle 1: write 0x041, stall=0, ready=0. Cycle 2: pipe granted if requesting; ext counter=2.
- Ext valid for 2 denied cycles then dropped, then re-asserted -> counter restarts at 0; forced grant after 4 further denied cycles.
- Ext read granted, reset asserted next cycle -> rvalid=0, rdata=0, all mem outputs 0 during reset; after release, an idle cycle shows mem_en=0.
